// File: rtl/de_3to8_if.sv
// Select-decoder bus: code/enable toward the decoder, registered select lines back.
// The chg strobe exists only when DE3TO8_CHG_EN is defined.
interface de_3to8_if #(
  parameter int IN_W = 3
);
  localparam int OUT_W = 1 << IN_W;

  logic             en;
  logic [IN_W-1:0]  in;
  logic [OUT_W-1:0] out;
  logic             valid;
`ifdef DE3TO8_CHG_EN
  logic             chg;

  modport master (output en, in, input out, valid, chg);
  modport slave  (input en, in, output out, valid, chg);
`else
  modport master (output en, in, input out, valid);
  modport slave  (input en, in, output out, valid);
`endif
endinterface

// File: rtl/de_3to8.sv
// Registered IN_W-to-2**IN_W one-hot decoder with enable: 1-cycle latency, accepts every cycle (no backpressure).
// Define DE3TO8_CHG_EN to add the chg strobe that marks any change of the registered select pattern.
module de_3to8 #(
  parameter int IN_W           = 3,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  de_3to8_if.slave  bus
);
  localparam int OUT_W = 1 << IN_W;
  localparam logic [OUT_W-1:0] INACTIVE = OUT_ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] nxt_out;
  logic [OUT_W-1:0] out_q;
  logic             valid_q;

  // Gating on en first keeps an unknown code from reaching the register while disabled.
  always_comb begin
    dec = '0;
    if (bus.en) begin
      dec[bus.in] = 1'b1;
    end
    nxt_out = dec ^ INACTIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= INACTIVE;
      valid_q <= 1'b0;
    end else begin
      out_q   <= nxt_out;
      valid_q <= bus.en;
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;

`ifdef DE3TO8_CHG_EN
  logic chg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= (nxt_out != out_q);
    end
  end

  assign bus.chg = chg_q;
`endif
endmodule

// File: tb/tb_de_3to8.sv
// Bench for de_3to8: three instances (active-high 3-bit, active-low 3-bit, active-high 2-bit) checked against a selected-index model.
module tb_de_3to8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] in  = 3'd0;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  de_3to8_if #(.IN_W(3)) bus_a ();
  de_3to8_if #(.IN_W(3)) bus_b ();
  de_3to8_if #(.IN_W(2)) bus_c ();

  assign bus_a.en = en;
  assign bus_a.in = in;
  assign bus_b.en = en;
  assign bus_b.in = in;
  assign bus_c.en = en;
  assign bus_c.in = in[1:0];

  de_3to8 #(.IN_W(3), .OUT_ACTIVE_LOW(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  de_3to8 #(.IN_W(3), .OUT_ACTIVE_LOW(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  de_3to8 #(.IN_W(2), .OUT_ACTIVE_LOW(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pattern: bit k is the selected line iff k equals the selected index (-1 = none).
  function automatic logic [7:0] pat8(input int sel, input bit low);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = (k == sel) ^ low;
    return r;
  endfunction

  function automatic logic [3:0] pat4(input int sel);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (k == sel);
    return r;
  endfunction

  // Model state: which line each decoder currently selects, plus a change flag.
  int sel3 = -1;
  int sel2 = -1;
  bit m_vld = 1'b0;
  bit m_chg3 = 1'b0;
  bit m_chg2 = 1'b0;

  always @(posedge clk or posedge rst) begin
    int n3;
    int n2;
    if (rst) begin
      sel3 = -1; sel2 = -1; m_vld = 1'b0; m_chg3 = 1'b0; m_chg2 = 1'b0;
    end else begin
      n3 = en ? int'(in) : -1;
      n2 = en ? int'(in[1:0]) : -1;
      m_chg3 = (n3 != sel3);
      m_chg2 = (n2 != sel2);
      sel3 = n3;
      sel2 = n2;
      m_vld = en;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_a", 32'(bus_a.out), 32'(pat8(sel3, 1'b0)));
      chk("out_b", 32'(bus_b.out), 32'(pat8(sel3, 1'b1)));
      chk("out_c", 32'(bus_c.out), 32'(pat4(sel2)));
      chk("valid_a", 32'(bus_a.valid), 32'(m_vld));
      chk("valid_b", 32'(bus_b.valid), 32'(m_vld));
      chk("valid_c", 32'(bus_c.valid), 32'(m_vld));
      chk("onehot_a", 32'($onehot0(bus_a.out)), 32'd1);
      chk("onehot_b", 32'($onehot0(~bus_b.out)), 32'd1);
`ifdef DE3TO8_CHG_EN
      chk("chg_a", 32'(bus_a.chg), 32'(m_chg3));
      chk("chg_b", 32'(bus_b.chg), 32'(m_chg3));
      chk("chg_c", 32'(bus_c.chg), 32'(m_chg2));
`endif
    end
  end

  initial begin
    logic [7:0] sweep [8];
    int hold;
    sweep = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Reset held with enable active and the clock running.
    rst = 1'b1; en = 1'b1; in = 3'd5;
    chk_on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_a", 32'(bus_a.out), 32'h00);
      chk("rst_valid_a", 32'(bus_a.valid), 32'd0);
      chk("rst_out_b", 32'(bus_b.out), 32'hFF);
    end

    // Released and disabled: code sweep must not show through.
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      @(negedge clk);
      chk("dis_out_a", 32'(bus_a.out), 32'h00);
    end
    in = 'x;
    @(negedge clk);
    chk("dis_x_out_a", 32'(bus_a.out), 32'h00);

    // Full sweep on consecutive edges.
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      @(negedge clk);
      chk("sweep_a", 32'(bus_a.out), 32'(sweep[i]));
      chk("sweep_valid", 32'(bus_a.valid), 32'd1);
      if (i == 6) chk("pol_low_b", 32'(bus_b.out), 32'hBF);
      if (i == 2) chk("width_c", 32'(bus_c.out), 32'h4);
    end

    // Enable toggle with code 3.
    in = 3'd3; en = 1'b1;
    @(negedge clk);
    chk("tog_on_a", 32'(bus_a.out), 32'h08);
`ifdef DE3TO8_CHG_EN
    chk("tog_on_chg", 32'(bus_a.chg), 32'd1);
`endif
    en = 1'b0;
    @(negedge clk);
    chk("tog_off_a", 32'(bus_a.out), 32'h00);
    chk("tog_off_b", 32'(bus_b.out), 32'hFF);
`ifdef DE3TO8_CHG_EN
    chk("tog_off_chg", 32'(bus_a.chg), 32'd1);
`endif
    en = 1'b1;
    @(negedge clk);
    chk("tog_on2_a", 32'(bus_a.out), 32'h08);
`ifdef DE3TO8_CHG_EN
    chk("tog_on2_chg", 32'(bus_a.chg), 32'd1);
`endif
    @(negedge clk);
    chk("tog_hold_a", 32'(bus_a.out), 32'h08);
`ifdef DE3TO8_CHG_EN
    chk("tog_hold_chg", 32'(bus_a.chg), 32'd0);
`endif

    // Asynchronous reset mid-cycle while out = 0x20.
    in = 3'd5;
    @(negedge clk);
    chk("pre_async_a", 32'(bus_a.out), 32'h20);
    #2 rst = 1'b1;
    #1;
    chk("async_out_a", 32'(bus_a.out), 32'h00);
    chk("async_valid_a", 32'(bus_a.valid), 32'd0);
    chk("async_out_b", 32'(bus_b.out), 32'hFF);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
`ifdef DE3TO8_CHG_EN
    chk("post_rst_chg", 32'(bus_a.chg), 32'd0);
`endif

    // Randomized traffic with occasional mid-cycle resets.
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      in = 3'($urandom_range(0, 7));
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 24) == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("rnd_async_a", 32'(bus_a.out), 32'h00);
        chk("rnd_async_b", 32'(bus_b.out), 32'hFF);
        hold = $urandom_range(1, 3);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
